periph_bus_arbiter: RTL and testbench
=====================================

# periph_bus_arbiter

Two-master arbiter and sequencer for the board-peripheral bus that drives the display/GPIO controller (DIP switches, touch buttons, LEDs, 7-segment digits). It accepts independent request/acknowledge transactions from the CPU data port (m0) and the debug/loader port (m1), grants them round-robin, and issues exactly one single-cycle `read_op` or `write_op` per grant. It then waits out the slave's registered read latency and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles from the `read_op` cycle until `bus_data_read` is valid. Legal range is 1..4.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `m0_req`, `m1_req`  in  1 each: transaction request. Held until the matching ack.
- `m0_we`, `m1_we`  in  1 each: 1 = write, 0 = read. Stable while req is high.
- `m0_addr`, `m1_addr`  in  Word_t each: byte address. Stable while req is high.
- `m0_wdata`, `m1_wdata`  in  Word_t each: write data. Stable while req is high.
- `m0_rdata`, `m1_rdata`  out  Word_t each: registered read data. Holds its value until the next read by the same master.
- `m0_ack`, `m1_ack`  out  1 each: one-cycle completion pulse, registered.
- `read_op`  out  1: slave read strobe.
- `write_op`  out  1: slave write strobe.
- `bus_addr`  out  Word_t: slave address.
- `bus_data_write`  out  Word_t: slave write data.
- `bus_data_read`  in  Word_t: slave read data, registered in the slave.
- `busy`  out  1: 1 in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, select a grant, latch that master's addr/wdata/we into the bus registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: exactly one cycle. Drive `read_op` = !we or `write_op` = we. Load the wait counter with `READ_LATENCY`. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the last WAIT cycle (counter = 1), for a read, capture `bus_data_read` into the granted master's rdata register.
  - Set the granted master's ack register and go to DONE.
  - Writes pass through WAIT identically but do not update rdata.
- DONE: the granted master's ack is high for this one cycle. Go to IDLE.
- Arbitration (IDLE only):
  - One req high: grant it.
  - Both high: grant the master not granted last.
  - `last_grant` updates on every grant and resets to 1, so m0 wins the first contention.
- Strobe rules:
  - `read_op` and `write_op` are never high together.
  - They are high only in ISSUE.
  - `bus_addr` and `bus_data_write` hold their values outside ISSUE.
- Requester rule: a master whose req is still high in the IDLE cycle after its ack is treated as a new transaction.
- No address decoding in this block. Undecoded reads return whatever the slave holds on `bus_data_read`.
- Req deasserted before ack (protocol violation): the transaction still completes and the ack is still pulsed.

## Timing
- Req first seen high in IDLE at cycle T:
  - ISSUE at T+1.
  - WAIT from T+2 to T+1+L.
  - ack high at T+2+L (T+3 for L = 1).
  - IDLE at T+3+L.
- Throughput: one transaction per 3+L cycles. There is no overlap between transactions.
- Contention: the loser's req is served in the IDLE after the winner's DONE. Worst-case wait is one full transaction.
- Reset values: `read_op`=0, `write_op`=0, `bus_addr`=0, `bus_data_write`=0, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0, `busy`=0, state=IDLE, `last_grant`=1, counter=0.
- Reset mid-transaction: the transaction is aborted, no ack is issued, and strobes drop immediately. A req still held is re-arbitrated in the first cycle after reset releases.

## Structure
- Shared package / `peripheral_defines.svh`:
  - `Bit_t` and `Word_t` (existing).
  - New `periph_arb_state_t` enum (IDLE, ISSUE, WAIT, DONE).
  - `ZERO_WORD` (existing).
- Sub-module `periph_rr_arb2`:
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: one-hot grant and a grant index.
  - Purely combinational.
  - `last_grant` stays in the parent, so the FSM controls when it updates.

## Test plan
- Single read: m0 reads the DIP-switch address with `dip_sw`=32'hA5A5_0F0F at L=1. Required response: exactly one `read_op` at T+1, `m0_ack` at T+3, `m0_rdata`=32'hA5A5_0F0F, `m1_ack` stays 0.
- Single write: m1 writes 32'h0000_BEEF to the LED address. Required response: one `write_op` at T+1 with `bus_data_write`=32'h0000_BEEF, `m1_ack` at T+3, `m1_rdata` unchanged (0).
- Contention: m0 and m1 both request reads in the same cycle after reset, with req held for a second transaction. Required grant order: m0, m1, m0, m1. Acks at T+3, T+7, T+11, T+15.
- Latency parameter: with `READ_LATENCY`=3 the slave model presents 32'h1234_5678 three cycles after `read_op`. Required response: ack at T+5, rdata=32'h1234_5678. A stale value shown earlier must not be captured.
- Reset mid-op: assert `rst` during WAIT of an m0 read. Required response: all outputs at reset values at once, no ack. After release with req held, a new `read_op` appears 1 cycle after the IDLE cycle.
- Strobe exclusivity: random mixed traffic for 10k cycles. Assertions must never fail: `read_op`&`write_op` never both high, each ack lasts exactly 1 cycle, exactly one strobe per ack.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types for the board-peripheral bus: word/bit types, reset word and
// the arbiter/sequencer FSM state encoding.
package periph_bus_arbiter_pkg;

  typedef logic        Bit_t;
  typedef logic [31:0] Word_t;

  localparam Word_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } periph_arb_state_t;

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational. On contention the master not
// granted last wins; the caller owns last_grant and decides when it moves.
module periph_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign gnt = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the peripheral bus: one strobe per
// grant, ack 2+READ_LATENCY cycles after grant, masters hold req until ack.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  m0_req,
  input  logic  m1_req,
  input  logic  m0_we,
  input  logic  m1_we,
  input  Word_t m0_addr,
  input  Word_t m1_addr,
  input  Word_t m0_wdata,
  input  Word_t m1_wdata,
  output Word_t m0_rdata,
  output Word_t m1_rdata,
  output logic  m0_ack,
  output logic  m1_ack,
  output logic  read_op,
  output logic  write_op,
  output Word_t bus_addr,
  output Word_t bus_data_write,
  input  Word_t bus_data_read,
  output logic  busy
);

  periph_arb_state_t state;
  Bit_t              last_grant;
  Bit_t              gnt_idx_q;
  Bit_t              we_q;
  logic [2:0]        cnt;

  logic [1:0] arb_gnt;
  logic       arb_idx;

  periph_rr_arb2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign read_op  = (state == ISSUE) && !we_q;
  assign write_op = (state == ISSUE) &&  we_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      gnt_idx_q      <= 1'b0;
      we_q           <= 1'b0;
      cnt            <= 3'd0;
      bus_addr       <= ZERO_WORD;
      bus_data_write <= ZERO_WORD;
      m0_rdata       <= ZERO_WORD;
      m1_rdata       <= ZERO_WORD;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            gnt_idx_q      <= arb_idx;
            last_grant     <= arb_idx;
            we_q           <= arb_gnt[1] ? m1_we    : m0_we;
            bus_addr       <= arb_gnt[1] ? m1_addr  : m0_addr;
            bus_data_write <= arb_gnt[1] ? m1_wdata : m0_wdata;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= READ_LATENCY[2:0];
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            // Slave data is valid exactly on the last wait cycle.
            if (!we_q) begin
              if (gnt_idx_q) m1_rdata <= bus_data_read;
              else           m0_rdata <= bus_data_read;
            end
            if (gnt_idx_q) m1_ack <= 1'b1;
            else           m0_ack <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: two instances (latency 1 and 3) on shared inputs,
// checked each cycle against a transaction-schedule reference model.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] bus_data_read;

  logic [31:0] o_rd0[2], o_rd1[2], o_baddr[2], o_bwd[2];
  logic        o_ack0[2], o_ack1[2], o_rop[2], o_wop[2], o_busy[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  periph_bus_arbiter #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m1_req(m_req[1]), .m0_we(m_we[0]), .m1_we(m_we[1]),
    .m0_addr(m_addr[0]), .m1_addr(m_addr[1]), .m0_wdata(m_wdata[0]), .m1_wdata(m_wdata[1]),
    .m0_rdata(o_rd0[0]), .m1_rdata(o_rd1[0]), .m0_ack(o_ack0[0]), .m1_ack(o_ack1[0]),
    .read_op(o_rop[0]), .write_op(o_wop[0]), .bus_addr(o_baddr[0]),
    .bus_data_write(o_bwd[0]), .bus_data_read(bus_data_read), .busy(o_busy[0])
  );

  periph_bus_arbiter #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m1_req(m_req[1]), .m0_we(m_we[0]), .m1_we(m_we[1]),
    .m0_addr(m_addr[0]), .m1_addr(m_addr[1]), .m0_wdata(m_wdata[0]), .m1_wdata(m_wdata[1]),
    .m0_rdata(o_rd0[1]), .m1_rdata(o_rd1[1]), .m0_ack(o_ack0[1]), .m1_ack(o_ack1[1]),
    .read_op(o_rop[1]), .write_op(o_wop[1]), .bus_addr(o_baddr[1]),
    .bus_data_write(o_bwd[1]), .bus_data_read(bus_data_read), .busy(o_busy[1])
  );

  // Reference model: one record per instance of the transaction in flight,
  // expressed as its grant cycle; all output timing follows from arithmetic on it.
  int          lat  [2] = '{1, 3};
  bit          act  [2];
  int          gc   [2];
  int          gm   [2];
  bit          gwe  [2];
  int          lastg[2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wd   [2];
  logic [31:0] e_rdata[2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; lastg[k] = 1; e_addr[k] = '0; e_wd[k] = '0;
      e_rdata[k][0] = '0; e_rdata[k][1] = '0;
    end
  endtask

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s lat=%0d cyc=%0d observed=%h expected=%h", tag, lat[k], cyc, obs, exp);
    end
  endtask

  task automatic decide();
    int w;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        act[k] = 1'b0; lastg[k] = 1; e_addr[k] = '0; e_wd[k] = '0;
        e_rdata[k][0] = '0; e_rdata[k][1] = '0;
      end else begin
        if (act[k] && cyc == gc[k] + 1 + lat[k] && !gwe[k])
          e_rdata[k][gm[k]] = bus_data_read;
        if ((!act[k] || cyc >= gc[k] + 3 + lat[k]) && m_req != 2'b00) begin
          if (m_req == 2'b11) w = 1 - lastg[k];
          else                w = m_req[1] ? 1 : 0;
          act[k] = 1'b1; gc[k] = cyc; gm[k] = w; gwe[k] = m_we[w];
          lastg[k] = w; e_addr[k] = m_addr[w]; e_wd[k] = m_wdata[w];
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit eb, er, ew, ea0, ea1;
    for (int k = 0; k < 2; k++) begin
      eb  = act[k] && cyc >= gc[k] + 1 && cyc <= gc[k] + 2 + lat[k];
      er  = act[k] && cyc == gc[k] + 1 && !gwe[k];
      ew  = act[k] && cyc == gc[k] + 1 &&  gwe[k];
      ea0 = act[k] && cyc == gc[k] + 2 + lat[k] && gm[k] == 0;
      ea1 = act[k] && cyc == gc[k] + 2 + lat[k] && gm[k] == 1;
      chk(k, "busy",     32'(o_busy[k]), 32'(eb));
      chk(k, "read_op",  32'(o_rop[k]),  32'(er));
      chk(k, "write_op", 32'(o_wop[k]),  32'(ew));
      chk(k, "excl",     32'(o_rop[k] & o_wop[k]), 32'd0);
      chk(k, "m0_ack",   32'(o_ack0[k]), 32'(ea0));
      chk(k, "m1_ack",   32'(o_ack1[k]), 32'(ea1));
      chk(k, "bus_addr", o_baddr[k], e_addr[k]);
      chk(k, "bus_wdat", o_bwd[k],   e_wd[k]);
      chk(k, "m0_rdata", o_rd0[k],   e_rdata[k][0]);
      chk(k, "m1_rdata", o_rd1[k],   e_rdata[k][1]);
    end
  endtask

  task automatic tick();
    decide();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    m_req = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; m_req = 2'b00; m_we = 2'b00; bus_data_read = '0;
    m_addr[0] = '0; m_addr[1] = '0; m_wdata[0] = '0; m_wdata[1] = '0;
    model_reset();
    #1;
    check_outputs();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single read of the DIP switches by m0.
    m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h0000_0010; bus_data_read = 32'hA5A5_0F0F;
    tick(); chk(0, "t1_rop_T1", 32'(o_rop[0]), 32'd1);
    tick(); chk(0, "t1_rop_T2", 32'(o_rop[0]), 32'd0);
    tick(); chk(0, "t1_ack_T3", 32'(o_ack0[0]), 32'd1); chk(0, "t1_m1ack", 32'(o_ack1[0]), 32'd0);
    m_req[0] = 1'b0;
    tick(); chk(0, "t1_rdata", o_rd0[0], 32'hA5A5_0F0F); chk(0, "t1_ack_T4", 32'(o_ack0[0]), 32'd0);
    idle(8);

    // Single write to the LEDs by m1.
    m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h0000_0020; m_wdata[1] = 32'h0000_BEEF;
    tick(); chk(0, "t2_wop", 32'(o_wop[0]), 32'd1); chk(0, "t2_bwd", o_bwd[0], 32'h0000_BEEF);
    tick();
    tick(); chk(0, "t2_ack_T3", 32'(o_ack1[0]), 32'd1);
    m_req[1] = 1'b0;
    tick(); chk(0, "t2_rdata", o_rd1[0], 32'h0000_0000);
    idle(8);

    // Contention straight after reset, each master holding req for two reads.
    rst = 1'b1; tick(); rst = 1'b0;
    m_we = 2'b00; m_req = 2'b11; m_addr[0] = 32'h0000_0010; m_addr[1] = 32'h0000_0014;
    for (int i = 1; i <= 16; i++) begin
      bus_data_read = 32'hC000_0000 + 32'(i);
      tick();
      chk(0, "t3_m0_ack", 32'(o_ack0[0]), 32'(i == 3 || i == 11));
      chk(0, "t3_m1_ack", 32'(o_ack1[0]), 32'(i == 7 || i == 15));
      if (i == 11) m_req[0] = 1'b0;
      if (i == 15) m_req[1] = 1'b0;
    end
    idle(8);

    // Latency 3: only the value presented three cycles after read_op is kept.
    m_req[0] = 1'b1; m_we[0] = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      bus_data_read = (i == 4) ? 32'h1234_5678 : 32'hDEAD_0000 + 32'(i);
      tick();
      chk(1, "t4_ack", 32'(o_ack0[1]), 32'(i + 1 == 5));
      if (i + 1 == 5) begin
        chk(1, "t4_rdata", o_rd0[1], 32'h1234_5678);
        m_req[0] = 1'b0;
      end
    end
    idle(8);

    // Reset during the wait cycle of an m0 read, req held through reset.
    m_req[0] = 1'b1; m_we[0] = 1'b0; bus_data_read = 32'h5555_AAAA;
    tick(); tick();
    chk(0, "t5_in_wait", 32'(o_busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk(0, "t5_rst_busy", 32'(o_busy[0]), 32'd0);
    chk(0, "t5_rst_rop",  32'(o_rop[0]),  32'd0);
    chk(0, "t5_rst_ack",  32'(o_ack0[0]), 32'd0);
    model_reset();
    check_outputs();
    tick();
    rst = 1'b0;
    tick(); chk(0, "t5_rearb_rop", 32'(o_rop[0]), 32'd1);
    tick();
    tick(); chk(0, "t5_ack", 32'(o_ack0[0]), 32'd1);
    m_req[0] = 1'b0;
    idle(8);

    // Random mixed traffic; masters hold req until their ack from the latency-1 instance.
    for (int n = 0; n < 10000; n++) begin
      bus_data_read = $urandom;
      for (int m = 0; m < 2; m++) begin
        if (m_req[m] && ((m == 0) ? o_ack0[0] : o_ack1[0])) begin
          if ($urandom_range(1, 0) == 0) m_req[m] = 1'b0;
        end else if (!m_req[m] && $urandom_range(3, 0) == 0) begin
          m_req[m]   = 1'b1;
          m_we[m]    = 1'($urandom_range(1, 0));
          m_addr[m]  = $urandom & 32'h0000_00FC;
          m_wdata[m] = $urandom;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
